// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Sequencer side: issues operands and start, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    // Adder side.
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one shared full-adder slice (two half adders + OR)
// processes one operand bit per clock, LSB first, with the carry registered
// between bits. start/busy/done handshake; sum/cout held until next completion.

// One half-adder cell; two of these plus an OR form the shared full adder.
module serial_add_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a, sh_b, acc, acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;
    logic             accept, last;
    logic             s1, c1, bit_s, c2, carry_nxt;

    // Shared full-adder slice built from two half-adder cells.
    serial_add_ha u_ha0 (.x(sh_a[0]), .y(sh_b[0]), .s(s1),    .c(c1));
    serial_add_ha u_ha1 (.x(s1),      .y(carry_r), .s(bit_s), .c(c2));
    assign carry_nxt = c1 | c2;

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_nxt = bit_s;
        end else begin : g_accn
            assign acc_nxt = {bit_s, acc[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Next-state decode; start is only honoured when no addition is running.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                accept  = bus.start;
                state_d = bus.start ? RUN : IDLE;
            end
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            acc     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            sh_a    <= bus.a;
            sh_b    <= bus.b;
            acc     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else if (state_q == RUN) begin
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            acc     <= acc_nxt;
            carry_r <= carry_nxt;
            cnt     <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= acc_nxt;
                cout_q <= carry_nxt;
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the main tests and
// a 1-bit instance for the degenerate width, sharing clock and reset.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one 8-bit addition and check latency, busy window, result and pulse width.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] es,
                        input logic ec, input string tag);
        int   n;
        logic busy_ok;
        bus8.start = 1'b1; bus8.a = ta; bus8.b = tb_;
        tick();
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        n = 0; busy_ok = 1'b1;
        while (!bus8.done && n < 40) begin
            if (!bus8.busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd8);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " sum"}, 32'(bus8.sum), 32'(es));
        check({tag, " cout"}, 32'(bus8.cout), 32'(ec));
        check({tag, " busy@done"}, 32'(bus8.busy), 32'd0);
        tick();
        check({tag, " done pulse"}, 32'(bus8.done), 32'd0);
        check({tag, " sum hold"}, 32'({bus8.cout, bus8.sum}), 32'({ec, es}));
    endtask

    vec_t vecs[8];
    vec_t v1[4];

    initial begin
        int n;
        int seen;
        logic [7:0] pa[3];
        logic [7:0] pb[3];

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[6] = '{8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[7] = '{8'hA5, 8'hC3, 8'h68, 1'b1};
        v1[0] = '{8'h0, 8'h0, 8'h0, 1'b0};
        v1[1] = '{8'h1, 8'h0, 8'h1, 1'b0};
        v1[2] = '{8'h0, 8'h1, 8'h1, 1'b0};
        v1[3] = '{8'h1, 8'h1, 8'h0, 1'b1};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst sum", 32'({bus8.cout, bus8.sum}), 32'd0);
        check("rst w1", 32'({bus1.busy, bus1.done, bus1.cout, bus1.sum}), 32'd0);

        // Table of single additions.
        for (int i = 0; i < 8; i++) run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

        // start re-asserted during RUN must be ignored.
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34;
        tick();
        n = 1;
        bus8.start = 1'b0;
        tick(); tick(); n += 2;
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'hAA;
        tick(); tick(); tick(); n += 3;
        bus8.start = 1'b0;
        check("ign sum stable", 32'({bus8.cout, bus8.sum}), 32'h168);
        seen = 0;
        while (!bus8.done && n < 40) begin tick(); n++; end
        check("ign latency", 32'(n), 32'd9);
        check("ign sum", 32'({bus8.cout, bus8.sum}), 32'h046);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.done) seen++;
        end
        check("ign one done", 32'(seen), 32'd0);

        // start held high: back-to-back operations, 9-cycle period.
        pa[0] = 8'h11; pb[0] = 8'h22;
        pa[1] = 8'hC8; pb[1] = 8'h64;
        pa[2] = 8'h3C; pb[2] = 8'h0F;
        bus8.start = 1'b1; bus8.a = pa[0]; bus8.b = pb[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin bus8.a = pa[i+1]; bus8.b = pb[i+1]; end
            else begin bus8.a = 8'hFF; bus8.b = 8'hFF; end
            n = 0;
            while (!bus8.done && n < 40) begin tick(); n++; end
            check($sformatf("b2b%0d latency", i), 32'(n), 32'd8);
            check($sformatf("b2b%0d result", i), 32'({bus8.cout, bus8.sum}),
                  32'({1'b0, pa[i]} + {1'b0, pb[i]}));
            if (i == 2) bus8.start = 1'b0;
            tick();
            check($sformatf("b2b%0d next busy", i), 32'(bus8.busy), (i < 2) ? 32'd1 : 32'd0);
        end

        // Reset in the 4th RUN cycle discards the partial result.
        bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst busy", 32'(bus8.busy), 32'd0);
        check("mrst done", 32'(bus8.done), 32'd0);
        check("mrst sum", 32'({bus8.cout, bus8.sum}), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.done || bus8.busy) seen++;
        end
        check("mrst quiet", 32'(seen), 32'd0);
        run8(8'h01, 8'h02, 8'h03, 1'b0, "post rst");

        // WIDTH=1 instance, exhaustive.
        for (int i = 0; i < 4; i++) begin
            bus1.start = 1'b1; bus1.a = v1[i].a[0]; bus1.b = v1[i].b[0];
            tick();
            bus1.start = 1'b0; bus1.a = ~bus1.a; bus1.b = ~bus1.b;
            n = 0;
            while (!bus1.done && n < 10) begin tick(); n++; end
            check($sformatf("w1 %0d latency", i), 32'(n), 32'd1);
            check($sformatf("w1 %0d result", i), 32'({bus1.cout, bus1.sum}),
                  32'({v1[i].c, v1[i].s[0]}));
            tick();
            check($sformatf("w1 %0d pulse", i), 32'(bus1.done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller that time-shares one 1-bit full-adder slice, built from two half-adder cells plus an OR, across all operand bits. One bit is processed per clock, LSB first, with carry held in a register between cycles. A start/busy/done handshake lets a simple sequencer or testbench issue additions. The result and carry-out are held stable until the next completion.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32
CNT_W, $clog2(WIDTH) (minimum 1), width of the internal bit counter; derived, not overridden

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request an addition; sampled only in IDLE or DONE
a  input  WIDTH  operand A; sampled on the edge that accepts start
b  input  WIDTH  operand B; sampled on the edge that accepts start
busy  output  1  high while the FSM is in RUN
done  output  1  one-cycle pulse; sum and cout are valid from this cycle
sum  output  WIDTH  registered result, a+b modulo 2^WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset: rst_n=0 at a rising edge forces the following:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and counter cleared.
  - Reset overrides every other input, including mid-RUN; a partial result is discarded and never appears on sum.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge: latch a into shA and b into shB; carry_r=0, cnt=0, acc=0; next state RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - Datapath: the first half-adder takes shA[0] and shB[0], giving s1 and c1. The second half-adder takes s1 and carry_r, giving bit and c2. carry_next = c1 OR c2.
  - acc shifts right with bit entering at MSB. shA and shB shift right. carry_r <= carry_next. cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge:
    - sum <= final acc value, including the current bit.
    - cout <= carry_next.
    - Next state DONE.
- DONE:
  - done=1 and busy=0 for exactly this one cycle.
  - At the next edge: start=1 accepts new operands exactly as in IDLE (back-to-back, next state RUN); otherwise next state IDLE.
- Latency:
  - The start-accept edge is E0. The edges E1..E_WIDTH each process one bit.
  - done is high during the cycle after E_WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Throughput is one addition per WIDTH+1 cycles with start held high.
- start while busy=1 is ignored. Operands are not re-sampled and the result is not disturbed.
- a and b may change freely after the accepting edge; the internal copies are used.
- sum and cout change only on the edge entering DONE, or on reset. They are stable at all other times, including during a subsequent RUN.
- WIDTH=1: RUN lasts one cycle; done follows the accepting edge by one cycle.
- Arithmetic: {cout,sum} equals a+b as an unsigned (WIDTH+1)-bit value.
- No combinational path from start, a or b to any output. All outputs are registered, or decoded from state only (busy, done).

Test Plan:
1. Reset, then WIDTH=8, a=0x5A, b=0x33, start pulsed one cycle -> busy high for 8 cycles; done pulses 8 cycles after the accept edge; sum=0x8D, cout=0.
2. a=0xFF, b=0x01, then a=0xFF, b=0xFF, then a=0x00, b=0x00 -> sum=0x00/cout=1, then 0xFE/1, then 0x00/0. Done pulses exactly once per operation.
3. Start accepted with a=0x12, b=0x34; start re-asserted with a=0xAA, b=0xAA during RUN -> ignored; result 0x46/0. Only one done pulse.
4. Start held high continuously; operands change after each done -> next RUN begins on the DONE-cycle edge with no IDLE cycle. Each result matches the operands latched at its own accept edge. Period is 9 cycles.
5. rst_n=0 for one edge at the 4th RUN cycle of 0xF0+0x0F -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE. No done pulse follows. A subsequent 0x01+0x02 yields 0x03/0.
6. WIDTH=1 build, exhaustive a,b in {0,1} -> done 1 cycle after accept; sum/cout = 0/0, 1/0, 1/0, 0/1.
